// File: rtl/pet_pkg.sv
// Shared types and constants for the pet game sequencer: FSM states,
// draw object codes and the need channel indices in priority order.
package pet_pkg;

  typedef enum logic [3:0] {
    ST_START     = 4'd0,
    ST_SCN_BG    = 4'd1,
    ST_SCN_PET   = 4'd2,
    ST_SCN_AGE   = 4'd3,
    ST_HOME      = 4'd4,
    ST_SELECT    = 4'd5,
    ST_BUB_DRAW  = 4'd6,
    ST_WAIT      = 4'd7,
    ST_ITM_DRAW  = 4'd8,
    ST_ITM_MOVE  = 4'd9,
    ST_SLP_DRAW  = 4'd10,
    ST_SLP_ANIM  = 4'd11,
    ST_DEAD_DRAW = 4'd12,
    ST_GO_DRAW   = 4'd13,
    ST_END_WAIT  = 4'd14
  } pet_state_e;

  localparam int OBJ_BG          = 0;
  localparam int OBJ_PET         = 1;
  localparam int OBJ_AGE         = 2;
  localparam int OBJ_ZS          = 3;
  localparam int OBJ_GAME_OVER   = 4;
  localparam int OBJ_SKULL       = 5;
  localparam int OBJ_BUBBLE_BASE = 8;
  localparam int OBJ_ITEM_BASE   = 16;

  // Lower index wins arbitration, so sickness is always attended first.
  typedef enum logic [2:0] {
    SICK   = 3'd0,
    HUNGRY = 3'd1,
    DIRTY  = 3'd2,
    BORED  = 3'd3,
    DYING  = 3'd4
  } pet_need_e;

  // States that hold draw_req high while waiting for the datapath.
  function automatic logic is_draw_state(input pet_state_e s);
    return (s == ST_SCN_BG)   || (s == ST_SCN_PET)   || (s == ST_SCN_AGE) ||
           (s == ST_BUB_DRAW) || (s == ST_ITM_DRAW)  || (s == ST_SLP_DRAW) ||
           (s == ST_DEAD_DRAW) || (s == ST_GO_DRAW);
  endfunction

  // States that hold move_req high while waiting for the datapath.
  function automatic logic is_move_state(input pet_state_e s);
    return (s == ST_ITM_MOVE) || (s == ST_SLP_ANIM);
  endfunction

  // States during which the pet is shown as dead.
  function automatic logic is_dead_state(input pet_state_e s);
    return (s == ST_DEAD_DRAW) || (s == ST_GO_DRAW) || (s == ST_END_WAIT);
  endfunction

endpackage

// File: rtl/prio_onehot_latch.sv
// Lowest-index-first priority encoder with a latch that remembers which
// need is being served. enc_idx exposes the unlatched winner so the owner
// can use it in the same cycle the latch loads.
module prio_onehot_latch
  import pet_pkg::*;
#(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             clear,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] enc_idx
);

  logic [N-1:0] enc_onehot;

  // Isolate the lowest set request bit as a one-hot vector.
  always_comb begin
    enc_onehot = req & (~req + N'(1));
  end

  // Binary index of the lowest set request bit; scanning downward lets the
  // lowest index overwrite any higher one.
  always_comb begin
    enc_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) enc_idx = IDX_W'(i);
    end
  end

  // Hold the selected need until the sequencer finishes or abandons it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      onehot <= '0;
      idx    <= '0;
    end else if (load) begin
      onehot <= enc_onehot;
      idx    <= enc_idx;
    end else if (clear) begin
      onehot <= '0;
      idx    <= '0;
    end
  end

endmodule

// File: rtl/pet_mood_sequencer.sv
// Game sequencer for the pet: arbitrates need channels, drives the VGA
// draw/animate datapath through req/done handshakes and tracks strikes
// for unattended bubbles up to death and game over.
module pet_mood_sequencer
  import pet_pkg::*;
#(
  parameter int NUM_NEEDS   = 5,
  parameter int OBJ_W       = 5,
  parameter int TMO_W       = 8,
  parameter int BUBBLE_TMO  = 200,
  parameter int MAX_STRIKES = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 go,
  input  logic                 tick,
  input  logic                 sleep,
  input  logic [NUM_NEEDS-1:0] need_req,
  input  logic [NUM_NEEDS-1:0] item_given,
  input  logic                 draw_done,
  input  logic                 move_done,
  output logic                 draw_req,
  output logic                 move_req,
  output logic [OBJ_W-1:0]     draw_obj,
  output logic [NUM_NEEDS-1:0] need_active,
  output logic [NUM_NEEDS-1:0] need_cleared,
  output logic [2:0]           strikes,
  output logic                 deceased
);

  localparam int IDX_W = (NUM_NEEDS > 1) ? $clog2(NUM_NEEDS) : 1;

  pet_state_e           state, state_nxt;
  logic [TMO_W-1:0]     tmo_cnt, tmo_nxt;
  logic [2:0]           strikes_nxt, strike_up;
  logic                 latch_load, latch_clear;
  logic [NUM_NEEDS-1:0] cleared_nxt;
  logic [IDX_W-1:0]     idx, enc_idx, obj_idx;
  logic [OBJ_W-1:0]     obj_nxt;

  prio_onehot_latch #(
    .N     (NUM_NEEDS),
    .IDX_W (IDX_W)
  ) u_need_latch (
    .clk     (clk),
    .resetn  (resetn),
    .load    (latch_load),
    .clear   (latch_clear),
    .req     (need_req),
    .onehot  (need_active),
    .idx     (idx),
    .enc_idx (enc_idx)
  );

  // Next-state, strike and bubble-timer decisions for the game flow.
  always_comb begin
    state_nxt   = state;
    tmo_nxt     = tmo_cnt;
    strikes_nxt = strikes;
    latch_load  = 1'b0;
    latch_clear = 1'b0;
    cleared_nxt = '0;
    strike_up   = (strikes == 3'd7) ? 3'd7 : strikes + 3'd1;
    case (state)
      ST_START:    if (go) state_nxt = ST_SCN_BG;
      ST_SCN_BG:   if (draw_done) state_nxt = ST_SCN_PET;
      ST_SCN_PET:  if (draw_done) state_nxt = ST_SCN_AGE;
      ST_SCN_AGE:  if (draw_done) state_nxt = ST_HOME;
      ST_HOME: begin
        if (sleep)          state_nxt = ST_SLP_DRAW;
        else if (|need_req) state_nxt = ST_SELECT;
      end
      ST_SELECT: begin
        latch_load = 1'b1;
        state_nxt  = (|need_req) ? ST_BUB_DRAW : ST_HOME;
      end
      ST_BUB_DRAW: begin
        if (draw_done) begin
          state_nxt = ST_WAIT;
          tmo_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (tick && (tmo_cnt != '1)) tmo_nxt = tmo_cnt + TMO_W'(1);
        if (|(item_given & need_active)) begin
          state_nxt = ST_ITM_DRAW;
        end else if (tick && (tmo_cnt == TMO_W'(BUBBLE_TMO - 1))) begin
          strikes_nxt = strike_up;
          latch_clear = 1'b1;
          state_nxt   = (strike_up == 3'(MAX_STRIKES)) ? ST_DEAD_DRAW : ST_SCN_BG;
        end
      end
      ST_ITM_DRAW: if (draw_done) state_nxt = ST_ITM_MOVE;
      ST_ITM_MOVE: begin
        if (move_done) begin
          cleared_nxt = need_active;
          strikes_nxt = (strikes == 3'd0) ? 3'd0 : strikes - 3'd1;
          latch_clear = 1'b1;
          state_nxt   = ST_SCN_BG;
        end
      end
      ST_SLP_DRAW:  if (draw_done) state_nxt = ST_SLP_ANIM;
      ST_SLP_ANIM:  if (move_done) state_nxt = ST_SCN_BG;
      ST_DEAD_DRAW: if (draw_done) state_nxt = ST_GO_DRAW;
      ST_GO_DRAW:   if (draw_done) state_nxt = ST_END_WAIT;
      ST_END_WAIT: begin
        if (go) begin
          strikes_nxt = 3'd0;
          state_nxt   = ST_SCN_BG;
        end
      end
      default: state_nxt = ST_START;
    endcase
  end

  // Object code for the request that will be active after this edge; the
  // need index comes straight from the encoder while it is being latched.
  always_comb begin
    obj_idx = (state == ST_SELECT) ? enc_idx : idx;
    case (state_nxt)
      ST_SCN_BG:    obj_nxt = OBJ_W'(OBJ_BG);
      ST_SCN_PET:   obj_nxt = OBJ_W'(OBJ_PET);
      ST_SCN_AGE:   obj_nxt = OBJ_W'(OBJ_AGE);
      ST_BUB_DRAW:  obj_nxt = OBJ_W'(OBJ_BUBBLE_BASE) + OBJ_W'(obj_idx);
      ST_ITM_DRAW,
      ST_ITM_MOVE:  obj_nxt = OBJ_W'(OBJ_ITEM_BASE) + OBJ_W'(obj_idx);
      ST_SLP_DRAW,
      ST_SLP_ANIM:  obj_nxt = OBJ_W'(OBJ_ZS);
      ST_DEAD_DRAW: obj_nxt = OBJ_W'(OBJ_SKULL);
      ST_GO_DRAW:   obj_nxt = OBJ_W'(OBJ_GAME_OVER);
      default:      obj_nxt = '0;
    endcase
  end

  // State register with outputs registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_START;
      tmo_cnt      <= '0;
      strikes      <= 3'd0;
      need_cleared <= '0;
      draw_req     <= 1'b0;
      move_req     <= 1'b0;
      draw_obj     <= '0;
      deceased     <= 1'b0;
    end else begin
      state        <= state_nxt;
      tmo_cnt      <= tmo_nxt;
      strikes      <= strikes_nxt;
      need_cleared <= cleared_nxt;
      draw_req     <= is_draw_state(state_nxt);
      move_req     <= is_move_state(state_nxt);
      draw_obj     <= obj_nxt;
      deceased     <= is_dead_state(state_nxt);
    end
  end

endmodule

// File: tb/tb_pet_mood_sequencer.sv
// Randomized bench for pet_mood_sequencer. A reference model tracks the
// game as a queue of planned screen jobs plus a few game-level facts
// (strikes, served need, death) and predicts every output each cycle.
module tb_pet_mood_sequencer;

  localparam int NN   = 5;
  localparam int OW   = 5;
  localparam int TW   = 8;
  localparam int TMO  = 3;
  localparam int MAXS = 2;
  localparam int NUM_CYCLES = 4000;

  logic          clk = 1'b0;
  logic          resetn, go, tick, sleep, draw_done, move_done;
  logic [NN-1:0] need_req, item_given;
  logic          draw_req, move_req, deceased;
  logic [OW-1:0] draw_obj;
  logic [NN-1:0] need_active, need_cleared;
  logic [2:0]    strikes;

  pet_mood_sequencer #(
    .NUM_NEEDS   (NN),
    .OBJ_W       (OW),
    .TMO_W       (TW),
    .BUBBLE_TMO  (TMO),
    .MAX_STRIKES (MAXS)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .go           (go),
    .tick         (tick),
    .sleep        (sleep),
    .need_req     (need_req),
    .item_given   (item_given),
    .draw_done    (draw_done),
    .move_done    (move_done),
    .draw_req     (draw_req),
    .move_req     (move_req),
    .draw_obj     (draw_obj),
    .need_active  (need_active),
    .need_cleared (need_cleared),
    .strikes      (strikes),
    .deceased     (deceased)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // What to do once a planned screen job is acknowledged.
  localparam int A_NONE  = 0;
  localparam int A_HOME  = 1;
  localparam int A_WAIT  = 2;
  localparam int A_ITEM  = 3;
  localparam int A_SCENE = 4;
  localparam int A_END   = 5;

  // Where the pet is when no screen job is outstanding.
  localparam int M_START  = 0;
  localparam int M_HOME   = 1;
  localparam int M_SELECT = 2;
  localparam int M_WAIT   = 3;
  localparam int M_END    = 4;

  typedef struct {
    bit mv;
    int obj;
    int act;
  } job_t;

  job_t plan[$];
  int   mode;
  int   m_strikes;
  int   m_active;
  int   m_ticks;
  int   m_cleared;
  bit   m_dead;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic pushJob(input bit mv, input int obj, input int act);
    job_t j;
    j.mv  = mv;
    j.obj = obj;
    j.act = act;
    plan.push_back(j);
  endtask

  task automatic pushScene();
    pushJob(1'b0, 0, A_NONE);
    pushJob(1'b0, 1, A_NONE);
    pushJob(1'b0, 2, A_HOME);
  endtask

  task automatic applyStimulus(input bit rst_n, input bit go_i, input bit tick_i,
                               input bit sleep_i, input logic [NN-1:0] need_i,
                               input logic [NN-1:0] item_i, input bit dd_i,
                               input bit md_i);
    resetn     = rst_n;
    go         = go_i;
    tick       = tick_i;
    sleep      = sleep_i;
    need_req   = need_i;
    item_given = item_i;
    draw_done  = dd_i;
    move_done  = md_i;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    job_t j;
    m_cleared = 0;
    if (!resetn) begin
      plan.delete();
      mode      = M_START;
      m_strikes = 0;
      m_active  = -1;
      m_ticks   = 0;
      m_dead    = 1'b0;
    end else if (plan.size() > 0) begin
      if ((plan[0].mv && move_done) || (!plan[0].mv && draw_done)) begin
        j = plan.pop_front();
        case (j.act)
          A_HOME: mode = M_HOME;
          A_WAIT: begin
            mode    = M_WAIT;
            m_ticks = 0;
          end
          A_ITEM: begin
            m_cleared = 1 << m_active;
            if (m_strikes > 0) m_strikes--;
            m_active = -1;
            pushScene();
          end
          A_SCENE: pushScene();
          A_END:   mode = M_END;
          default: ;
        endcase
      end
    end else begin
      case (mode)
        M_START: if (go) pushScene();
        M_HOME: begin
          if (sleep) begin
            pushJob(1'b0, 3, A_NONE);
            pushJob(1'b1, 3, A_SCENE);
          end else if (need_req != 0) begin
            mode = M_SELECT;
          end
        end
        M_SELECT: begin
          if (need_req == 0) begin
            mode = M_HOME;
          end else begin
            for (int i = 0; i < NN; i++) begin
              if (need_req[i]) begin
                m_active = i;
                break;
              end
            end
            pushJob(1'b0, 8 + m_active, A_WAIT);
          end
        end
        M_WAIT: begin
          if (item_given[m_active]) begin
            pushJob(1'b0, 16 + m_active, A_NONE);
            pushJob(1'b1, 16 + m_active, A_ITEM);
          end else if (tick) begin
            m_ticks++;
            if (m_ticks == TMO) begin
              if (m_strikes < 7) m_strikes++;
              m_active = -1;
              if (m_strikes == MAXS) begin
                m_dead = 1'b1;
                pushJob(1'b0, 5, A_NONE);
                pushJob(1'b0, 4, A_END);
              end else begin
                pushScene();
              end
            end
          end
        end
        M_END: begin
          if (go) begin
            m_strikes = 0;
            m_dead    = 1'b0;
            pushScene();
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compareAll();
    bit busy;
    busy = (plan.size() > 0);
    checkOutput("draw_req", draw_req, busy && !plan[0].mv);
    checkOutput("move_req", move_req, busy && plan[0].mv);
    checkOutput("draw_obj", draw_obj, busy ? plan[0].obj : 0);
    checkOutput("need_active", need_active, (m_active < 0) ? 0 : (1 << m_active));
    checkOutput("need_cleared", need_cleared, m_cleared);
    checkOutput("strikes", strikes, m_strikes);
    checkOutput("deceased", deceased, m_dead);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      @(negedge clk);
      if (cyc > 0) compareAll();
      if (cyc < 2) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      end else begin
        applyStimulus($urandom_range(0, 299) != 0,
                      $urandom_range(0, 5) == 0,
                      $urandom_range(0, 1) == 1,
                      $urandom_range(0, 9) == 0,
                      ($urandom_range(0, 3) == 0) ? '0 : NN'($urandom),
                      ($urandom_range(0, 5) == 0) ? NN'($urandom) : '0,
                      $urandom_range(0, 2) == 0,
                      $urandom_range(0, 2) == 0);
      end
      modelStep();
    end
    @(negedge clk);
    compareAll();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pet_mood_sequencer.md
Name: pet_mood_sequencer

Overview:
Parametrised top-level game sequencer for the pet. It replaces the fixed five-mood controller with a generic engine for NUM_NEEDS need channels. It arbitrates needs by priority and drives the VGA draw/animate datapath through a req/done handshake. It also counts unattended bubbles (strikes), escalating to death and game over.

Parameters:
NUM_NEEDS, 5, number of need channels; index 0 is highest priority; legal range 1..8
OBJ_W, 5, width of draw object code
TMO_W, 8, width of bubble timeout counter
BUBBLE_TMO, 200, ticks a bubble waits for care before it counts as a strike; 1..2^TMO_W-1
MAX_STRIKES, 4, strike count at which the pet dies; 1..7

Ports:
clk  in  1  system clock
resetn  in  1  synchronous reset, active-low
go  in  1  start / restart request, level
tick  in  1  one-cycle game-time pulse
sleep  in  1  sleep request, level
need_req  in  NUM_NEEDS  pending need flags from the stats block
item_given  in  NUM_NEEDS  user care-item press, one bit per need
draw_done  in  1  datapath finished current plot, one-cycle pulse
move_done  in  1  datapath finished current animation, one-cycle pulse
draw_req  out  1  plot request, held until draw_done
move_req  out  1  animate request, held until move_done
draw_obj  out  OBJ_W  object code for current req
need_active  out  NUM_NEEDS  one-hot latched need being served; 0 otherwise
need_cleared  out  NUM_NEEDS  one-cycle pulse; need satisfied, stats block clears it
strikes  out  3  current strike count
deceased  out  1  high from DEAD entry until restart

Behaviour:
- Reset (resetn=0 at posedge): state=START; strikes=0; tmo_cnt=0; all outputs 0. Reset mid-handshake abandons the request with no pulse.
- Object codes:
  - BG=0, PET=1, AGE=2, ZS=3, GAME_OVER=4, SKULL=5.
  - Bubble for need i = 8+i.
  - Item for need i = 16+i.
- draw_obj is valid and stable whenever draw_req or move_req is high, and is 0 otherwise.
- Handshake:
  - In a draw state, draw_req=1. On the cycle draw_done=1 is sampled, the next state is taken, so draw_req drops the following cycle.
  - move_req/move_done behave identically.
  - A done pulse arriving in a non-requesting state is ignored.
- States and transitions:
  - START: go -> SCN_BG.
  - SCN_BG -> SCN_PET -> SCN_AGE: each advances on draw_done. SCN_AGE goes to HOME.
  - HOME:
    - sleep -> SLP_DRAW (sleep has priority over needs).
    - Otherwise, any need_req -> SELECT.
    - Otherwise stay in HOME.
  - SELECT: latch idx = lowest set bit of need_req into need_active, then go to BUB_DRAW. If need_req==0 on that cycle, return to HOME.
  - BUB_DRAW: draw_obj=8+idx; draw_done -> WAIT; tmo_cnt cleared.
  - WAIT: on each tick, tmo_cnt+1. Evaluate in this priority order:
    - item_given[idx] -> ITM_DRAW.
    - Otherwise, tick with tmo_cnt==BUBBLE_TMO-1 -> strike: strikes+1.
      - If the new count equals MAX_STRIKES -> DEAD_DRAW.
      - Otherwise -> SCN_BG, with need_active cleared.
    - item_given bits other than idx are ignored.
  - ITM_DRAW: draw_obj=16+idx; draw_done -> ITM_MOVE.
  - ITM_MOVE: move_done -> need_cleared[idx] pulse for 1 cycle; strikes decrements, saturating at 0; need_active=0; go to SCN_BG.
  - SLP_DRAW: draw_obj=ZS; draw_done -> SLP_ANIM. SLP_ANIM: move_done -> SCN_BG.
  - DEAD_DRAW: deceased=1; draw_obj=SKULL; draw_done -> GO_DRAW.
  - GO_DRAW: draw_obj=GAME_OVER; draw_done -> END_WAIT.
  - END_WAIT: go -> strikes=0, deceased=0, then SCN_BG.
- Simultaneous events:
  - item_given and timeout tick in the same cycle: item wins, no strike.
  - need_req changing after SELECT has no effect until the next SELECT.
- Width rules:
  - strikes saturates at 7; it never wraps.
  - tmo_cnt saturates at its maximum value.
- Undefined state encodings -> START.

Decomposition:
- Package pet_pkg holds:
  - the state enum typedef;
  - the object code localparams (OBJ_BG .. OBJ_SKULL, OBJ_BUBBLE_BASE=8, OBJ_ITEM_BASE=16);
  - the pet_need_e index constants (SICK=0, HUNGRY=1, DIRTY=2, BORED=3, DYING=4), which preserve the existing priority order.
- One sub-module: prio_onehot_latch. It takes a NUM_NEEDS-wide lowest-index priority encoder plus a load enable, and outputs the one-hot result and a binary index.

Test Plan:
- Boot: go=1 for 1 cycle; answer each draw_req with draw_done 2 cycles later -> draw_obj sequence 0,1,2 observed, then HOME with draw_req=0.
- Priority: need_req=5'b01010 in HOME -> need_active=5'b00010; draw_obj=9. After draw_done, item_given=5'b01000 is ignored. item_given=5'b00010 -> draw_obj=17, then move_req. After move_done, need_cleared=5'b00010 for exactly 1 cycle.
- Timeout: BUBBLE_TMO=3; in WAIT give 3 ticks and no item -> strikes 0->1; next draw_obj=0; need_active=0.
- Collision: in WAIT at tmo_cnt=BUBBLE_TMO-1, assert tick and item_given[idx] together -> ITM_DRAW entered; strikes unchanged.
- Death/restart: MAX_STRIKES=2; cause 2 timeouts -> deceased=1; draw_obj 5 then 4; END_WAIT. Then go -> strikes=0, deceased=0, draw_obj=0.
- Sleep and reset: sleep=1 and need_req!=0 in HOME -> draw_obj=3 first. Assert resetn=0 while move_req=1 -> next cycle START, move_req=0, strikes=0.
